// File: rtl/arb_mux_rr_pkg.sv
// rtl/arb_mux_rr_pkg.sv - shared helpers for the registered arbitrating muxes
package arb_mux_rr_pkg;

  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Channel ch occupies in_data[ch_lo(ch, width) +: width].
  function automatic int ch_lo(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/arb_mux_rr_rr_pick.sv
// rtl/arb_mux_rr_rr_pick.sv - find-first-set starting at a rotating base index
module rr_pick
  import arb_mux_rr_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int SEL_W  = clog2_f(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  base,
  output logic              gnt_valid,
  output logic [SEL_W-1:0]  gnt_idx
);

  // Scan from the far end back toward base so the nearest request wins last.
  always_comb begin
    int j;
    j         = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      j = int'(base) + i;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (req[j]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SEL_W'(j);
      end
    end
  end

endmodule

// File: rtl/arb_mux_rr.sv
// rtl/arb_mux_rr.sv - N-channel registered mux with round-robin/fixed arbitration
module arb_mux_rr
  import arb_mux_rr_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int NUM_CH = 8,
  parameter int SEL_W  = clog2_f(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fixed_pri,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  input  logic                    out_ready
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] base;
  logic             gnt_valid;
  logic [SEL_W-1:0] gnt_idx;
  logic             space;
  logic             accept;
  logic [WIDTH-1:0] words [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign words[i] = in_data[ch_lo(i, WIDTH) +: WIDTH];
  end

  assign base = fixed_pri ? '0 : ptr;

  rr_pick #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_pick (
    .req       (in_valid),
    .base      (base),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Reset blocks acceptance so nothing is consumed while the held word is dropped.
  assign space  = (!out_valid || out_ready) && !rst;
  assign accept = gnt_valid && space;

  always_comb begin
    in_ready = '0;
    if (accept) in_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= words[gnt_idx];
      out_ch    <= gnt_idx;
      if (!fixed_pri) begin
        ptr <= (gnt_idx == SEL_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
